bcd_calc_seq: RTL and testbench
===============================

// Module: bcd_calc_seq
// PURPOSE
//  Parametrised keypad calculator sequencer. Accepts decoded key events from the keypad reader.
//  Builds two DIGITS-wide BCD operands, then adds or subtracts them digit-serially.
//  Drives the BCD value to be shown on the 7-segment display driver, plus sign/overflow flags.
//  Replaces the fixed 4-digit add-only sequencer with operator modes, chaining and clean handshakes.
// PARAMETERS
//  DIGITS  4  number of BCD digits per operand/result (>=1); display bus is 4*DIGITS bits
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst        in   1           asynchronous, active-low reset
//  key_valid  in   1           one-cycle strobe: key_code is valid this cycle
//  key_code   in   4           0x0-0x9 digit, 0xA add, 0xB sub, 0xC clear, 0xE equals; 0xD/0xF ignored
//  disp_bcd   out  4*DIGITS    BCD value for display, digit 0 = bits [3:0] (LSD)
//  disp_neg   out  1           result is negative (shown only in RES state)
//  ovf        out  1           addition carried out of MSD
//  op_sub     out  1           latched operator: 0 add, 1 subtract
//  busy       out  1           high while computing; keys ignored while high
//  res_valid  out  1           one-cycle pulse when result is written to disp_bcd
// BEHAVIOUR
//  Reset (rst=0, async): state=ENTER_A; A=B=0; digit counts=0.
//   Outputs on reset: disp_bcd=0, disp_neg=0, ovf=0, op_sub=0, busy=0, res_valid=0.
//  States: ENTER_A, ENTER_B, CALC, RES. A key is "accepted" when key_valid=1 and busy=0.
//  Digit entry (ENTER_A / ENTER_B): operand <= {operand[4*DIGITS-5:0], key}; count++.
//   Once count==DIGITS, further digits are ignored. No wrap, no shift-out.
//  ENTER_A:
//   op key -> op_sub latched (A=0, B=1); B cleared; go ENTER_B.
//   equals -> ignored.
//  ENTER_B:
//   digit -> enter into B.
//   op key -> re-latch op_sub only.
//   equals -> go CALC.
//  CALC: busy=1 for exactly DIGITS cycles, one digit per cycle, LSD first.
//   Add: BCD digit add with carry (+6 correction if sum>9).
//    ovf = final carry out of MSD; result = low DIGITS digits.
//   Sub: the A>=B compare is done when equals is accepted (BCD vectors compare as unsigned).
//    Compute larger minus smaller via digit borrow; disp_neg = (A<B); ovf=0.
//   Timing: equals accepted at edge t -> busy=1 from t..t+DIGITS-1.
//    At edge t+DIGITS: state=RES, busy=0, disp_bcd=result, res_valid=1 for one cycle.
//  RES:
//   digit -> A cleared then digit entered, go ENTER_A.
//   op key -> A=result magnitude (sign dropped), op latched, B cleared, go ENTER_B.
//   equals -> ignored.
//  clear (0xC) in any non-CALC state -> A=B=0, counts=0, go ENTER_A. op_sub is kept.
//  disp_neg and ovf clear on any accepted key; they are valid only in RES.
//  disp_bcd shows: A in ENTER_A; B in ENTER_B and during CALC (held); result in RES.
//  Keys arriving while busy=1 are dropped silently, including clear. No queueing.
//  Reset asserted mid-CALC aborts immediately to the reset values. No partial result is shown.
//  Ignored codes (0xD, 0xF) change nothing, including the flags.
// TESTING (DIGITS=4 unless noted)
//  1 Keys 1,2,3,4,A,0,0,6,6,E -> after 4 busy cycles: disp_bcd=16'h1300, ovf=0, neg=0, res_valid one pulse.
//  2 Keys 9,9,9,9,A,0,0,0,1,E -> disp_bcd=16'h0000, ovf=1; then key 5 -> disp_bcd=16'h0005, ovf=0, ENTER_A.
//  3 Keys 2,5,B,1,0,0,E -> disp_bcd=16'h0075, disp_neg=1; then A,5,E -> disp_bcd=16'h0080, neg=0 (chaining).
//  4 Keys 1,2,3,4,5 -> disp_bcd=16'h1234 (5th ignored); C -> 16'h0000; E in ENTER_A -> no change.
//  5 Send key 7 and C while busy=1 -> both ignored, result unaffected.
//    Drop rst mid-CALC -> all outputs zero asynchronously.
//  6 DIGITS=6: 4,5,0,0,0,0,A,5,5,0,0,0,0,E -> disp_bcd=24'h000000, ovf=1; busy exactly 6 cycles.

Source files
------------

// File: rtl/bcd_calc_seq.sv
// rtl/bcd_calc_seq.sv - keypad BCD calculator sequencer with digit-serial add/subtract
module bcd_calc_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic [4*DIGITS-1:0] disp_bcd,
    output logic                disp_neg,
    output logic                ovf,
    output logic                op_sub,
    output logic                busy,
    output logic                res_valid
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    localparam logic [1:0] S_ENTER_A = 2'd0;
    localparam logic [1:0] S_ENTER_B = 2'd1;
    localparam logic [1:0] S_CALC    = 2'd2;
    localparam logic [1:0] S_RES     = 2'd3;

    logic [1:0]    state;
    logic [W-1:0]  a, b, result, x, y;
    logic [CW-1:0] cnt_a, cnt_b, idx;
    logic          carry, neg;
    logic          accept, is_digit, is_op, is_clr, is_eq, is_ign;
    logic [4:0]    sum, diff;
    logic [3:0]    dig;
    logic          cout;

    assign accept   = key_valid && !busy;
    assign is_digit = (key_code <= 4'd9);
    assign is_op    = (key_code == 4'hA) || (key_code == 4'hB);
    assign is_clr   = (key_code == 4'hC);
    assign is_eq    = (key_code == 4'hE);
    assign is_ign   = (key_code == 4'hD) || (key_code == 4'hF);

    // x holds the larger operand for subtraction, so the final borrow is always zero
    always_comb begin
        sum  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'd0, carry};
        diff = {1'b0, x[3:0]} - {1'b0, y[3:0]} - {4'd0, carry};
        dig  = sum[3:0];
        cout = 1'b0;
        if (op_sub) begin
            dig  = diff[3:0];
            cout = diff[4];
            if (diff[4]) dig = diff[3:0] + 4'd10;
        end else if (sum > 5'd9) begin
            dig  = sum[3:0] + 4'd6;
            cout = 1'b1;
        end
    end

    always_comb begin
        disp_bcd = b;
        if (state == S_ENTER_A) disp_bcd = a;
        else if (state == S_RES) disp_bcd = result;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_ENTER_A;
            a         <= '0;
            b         <= '0;
            result    <= '0;
            x         <= '0;
            y         <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            neg       <= 1'b0;
            disp_neg  <= 1'b0;
            ovf       <= 1'b0;
            op_sub    <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (state == S_CALC) begin
                x      <= x >> 4;
                y      <= y >> 4;
                result <= (result >> 4) | (W'(dig) << (W - 4));
                carry  <= cout;
                idx    <= idx + CW'(1);
                if (idx == LAST) begin
                    state     <= S_RES;
                    busy      <= 1'b0;
                    res_valid <= 1'b1;
                    disp_neg  <= neg;
                    ovf       <= !op_sub && cout;
                end
            end else if (accept && !is_ign) begin
                disp_neg <= 1'b0;
                ovf      <= 1'b0;
                if (is_clr) begin
                    a     <= '0;
                    b     <= '0;
                    cnt_a <= '0;
                    cnt_b <= '0;
                    state <= S_ENTER_A;
                end else begin
                    case (state)
                        S_ENTER_A: begin
                            if (is_digit && cnt_a != FULL) begin
                                a     <= (a << 4) | W'(key_code);
                                cnt_a <= cnt_a + CW'(1);
                            end else if (is_op) begin
                                op_sub <= key_code[0];
                                b      <= '0;
                                cnt_b  <= '0;
                                state  <= S_ENTER_B;
                            end
                        end
                        S_ENTER_B: begin
                            if (is_digit && cnt_b != FULL) begin
                                b     <= (b << 4) | W'(key_code);
                                cnt_b <= cnt_b + CW'(1);
                            end else if (is_op) begin
                                op_sub <= key_code[0];
                            end else if (is_eq) begin
                                state <= S_CALC;
                                busy  <= 1'b1;
                                idx   <= '0;
                                carry <= 1'b0;
                                neg   <= op_sub && (a < b);
                                if (op_sub && (a < b)) begin
                                    x <= b;
                                    y <= a;
                                end else begin
                                    x <= a;
                                    y <= b;
                                end
                            end
                        end
                        S_RES: begin
                            if (is_digit) begin
                                a     <= W'(key_code);
                                cnt_a <= CW'(1);
                                state <= S_ENTER_A;
                            end else if (is_op) begin
                                a      <= result;
                                op_sub <= key_code[0];
                                b      <= '0;
                                cnt_b  <= '0;
                                state  <= S_ENTER_B;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_bcd_calc_seq.sv
// tb/tb_bcd_calc_seq.sv - self-checking bench for bcd_calc_seq with a decimal reference model
module tb_bcd_calc_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        kv, kv6;
    logic [3:0]  kc, kc6;
    logic [15:0] disp;
    logic        neg, ovf, sub, busy, rv;
    logic [23:0] disp6;
    logic        neg6, ovf6, sub6, busy6, rv6;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_calc_seq #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .key_valid(kv), .key_code(kc), .disp_bcd(disp),
        .disp_neg(neg), .ovf(ovf), .op_sub(sub), .busy(busy), .res_valid(rv)
    );

    bcd_calc_seq #(.DIGITS(6)) dut6 (
        .clk(clk), .rst(rst), .key_valid(kv6), .key_code(kc6), .disp_bcd(disp6),
        .disp_neg(neg6), .ovf(ovf6), .op_sub(sub6), .busy(busy6), .res_valid(rv6)
    );

    // Reference model: operands kept as plain decimal integers
    localparam int ST_A = 0, ST_B = 1, ST_RES = 2;
    int m_st, m_a, m_b, m_ca, m_cb, m_res;
    bit m_sub, m_neg, m_ovf;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int v;
        v = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_disp();
        if (m_st == ST_A) return to_bcd(m_a);
        if (m_st == ST_RES) return to_bcd(m_res);
        return to_bcd(m_b);
    endfunction

    task automatic model_reset();
        m_st = ST_A; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_res = 0;
        m_sub = 0; m_neg = 0; m_ovf = 0;
    endtask

    task automatic model_key(input int code, output bit calc);
        int r;
        calc = 0;
        if (code == 13 || code == 15) return;
        m_neg = 0;
        m_ovf = 0;
        if (code == 12) begin
            m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_st = ST_A;
            return;
        end
        case (m_st)
            ST_A: begin
                if (code <= 9) begin
                    if (m_ca < 4) begin m_a = m_a * 10 + code; m_ca++; end
                end else if (code == 10 || code == 11) begin
                    m_sub = (code == 11); m_b = 0; m_cb = 0; m_st = ST_B;
                end
            end
            ST_B: begin
                if (code <= 9) begin
                    if (m_cb < 4) begin m_b = m_b * 10 + code; m_cb++; end
                end else if (code == 10 || code == 11) begin
                    m_sub = (code == 11);
                end else if (code == 14) begin
                    calc = 1;
                    if (!m_sub) begin
                        r = m_a + m_b;
                        m_ovf = (r >= 10000);
                        m_res = r % 10000;
                    end else begin
                        m_neg = (m_a < m_b);
                        m_res = m_neg ? m_b - m_a : m_a - m_b;
                    end
                    m_st = ST_RES;
                end
            end
            default: begin
                if (code <= 9) begin
                    m_a = code; m_ca = 1; m_st = ST_A;
                end else if (code == 10 || code == 11) begin
                    m_a = m_res; m_sub = (code == 11); m_b = 0; m_cb = 0; m_st = ST_B;
                end
            end
        endcase
    endtask

    task automatic press(input int code);
        bit c;
        @(negedge clk);
        kv = 1'b1;
        kc = 4'(code);
        @(negedge clk);
        kv = 1'b0;
        model_key(code, c);
    endtask

    task automatic press6(input int code);
        @(negedge clk);
        kv6 = 1'b1;
        kc6 = 4'(code);
        @(negedge clk);
        kv6 = 1'b0;
    endtask

    task automatic measure_busy(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic measure_busy6(output int cyc);
        cyc = 0;
        while (busy6 === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0; kv = 0; kc = 0; kv6 = 0; kc6 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({disp, neg, ovf, sub, busy, rv} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got disp=%h neg=%b ovf=%b sub=%b busy=%b rv=%b, want all 0", disp, neg, ovf, sub, busy, rv);
        end
        n_tests++;
        if ({disp6, neg6, ovf6, sub6, busy6, rv6} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs6: got disp=%h busy=%b rv=%b, want all 0", disp6, busy6, rv6);
        end
        rst = 1'b1;
    endtask

    task automatic test_add();
        int cyc;
        int keys[9] = '{1, 2, 3, 4, 10, 0, 0, 6, 6};
        foreach (keys[i]) press(keys[i]);
        n_tests++;
        if (disp !== 16'h0066) begin n_fail++; $display("FAIL add_show_b: got %h want 0066", disp); end
        press(14);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_start: got %b want 1", busy); end
        measure_busy(cyc);
        n_tests++;
        if (cyc != 4) begin n_fail++; $display("FAIL add_busy_cycles: got %0d want 4", cyc); end
        n_tests++;
        if ({disp, ovf, neg, rv} !== {16'h1300, 3'b001}) begin
            n_fail++;
            $display("FAIL add_result: got disp=%h ovf=%b neg=%b rv=%b want 1300 0 0 1", disp, ovf, neg, rv);
        end
        @(negedge clk);
        n_tests++;
        if (rv !== 1'b0) begin n_fail++; $display("FAIL add_rv_pulse: got %b want 0", rv); end
    endtask

    task automatic test_overflow();
        int cyc;
        int keys[9] = '{9, 9, 9, 9, 10, 0, 0, 0, 1};
        foreach (keys[i]) press(keys[i]);
        press(14);
        measure_busy(cyc);
        n_tests++;
        if ({disp, ovf, rv} !== {16'h0000, 2'b11}) begin
            n_fail++;
            $display("FAIL ovf_result: got disp=%h ovf=%b rv=%b want 0000 1 1", disp, ovf, rv);
        end
        press(5);
        n_tests++;
        if ({disp, ovf} !== {16'h0005, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_next_digit: got disp=%h ovf=%b want 0005 0", disp, ovf);
        end
    endtask

    task automatic test_sub_chain();
        int cyc;
        int keys[7] = '{12, 2, 5, 11, 1, 0, 0};
        foreach (keys[i]) press(keys[i]);
        press(14);
        measure_busy(cyc);
        n_tests++;
        if ({disp, neg, sub, ovf} !== {16'h0075, 3'b110}) begin
            n_fail++;
            $display("FAIL sub_neg_result: got disp=%h neg=%b sub=%b ovf=%b want 0075 1 1 0", disp, neg, sub, ovf);
        end
        press(10);
        press(5);
        press(14);
        measure_busy(cyc);
        n_tests++;
        if ({disp, neg, sub} !== {16'h0080, 2'b00}) begin
            n_fail++;
            $display("FAIL chain_result: got disp=%h neg=%b sub=%b want 0080 0 0", disp, neg, sub);
        end
    endtask

    task automatic test_entry_limit();
        int keys[6] = '{12, 1, 2, 3, 4, 5};
        foreach (keys[i]) press(keys[i]);
        n_tests++;
        if (disp !== 16'h1234) begin n_fail++; $display("FAIL entry_limit: got %h want 1234", disp); end
        press(12);
        n_tests++;
        if (disp !== 16'h0000) begin n_fail++; $display("FAIL clear: got %h want 0000", disp); end
        press(14);
        n_tests++;
        if ({disp, busy} !== 17'd0) begin
            n_fail++;
            $display("FAIL eq_in_enter_a: got disp=%h busy=%b want 0000 0", disp, busy);
        end
    endtask

    task automatic test_busy_drop();
        int cyc;
        int keys[5] = '{1, 2, 10, 3, 4};
        foreach (keys[i]) press(keys[i]);
        press(14);
        kv = 1'b1; kc = 4'd7;
        @(negedge clk);
        kc = 4'hC;
        @(negedge clk);
        kv = 1'b0;
        measure_busy(cyc);
        n_tests++;
        if (cyc + 2 != 4) begin n_fail++; $display("FAIL drop_busy_cycles: got %0d want 4", cyc + 2); end
        n_tests++;
        if ({disp, rv} !== {16'h0046, 1'b1}) begin
            n_fail++;
            $display("FAIL drop_result: got disp=%h rv=%b want 0046 1", disp, rv);
        end
        press(1); press(10); press(1); press(14);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({disp, neg, ovf, sub, busy, rv} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_mid_calc: got disp=%h busy=%b rv=%b want all 0", disp, busy, rv);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_digits6();
        int cyc;
        int keys[13] = '{4, 5, 0, 0, 0, 0, 10, 5, 5, 0, 0, 0, 0};
        foreach (keys[i]) press6(keys[i]);
        n_tests++;
        if (disp6 !== 24'h550000) begin n_fail++; $display("FAIL d6_show_b: got %h want 550000", disp6); end
        press6(14);
        measure_busy6(cyc);
        n_tests++;
        if (cyc != 6) begin n_fail++; $display("FAIL d6_busy_cycles: got %0d want 6", cyc); end
        n_tests++;
        if ({disp6, ovf6, rv6} !== {24'h000000, 2'b11}) begin
            n_fail++;
            $display("FAIL d6_result: got disp=%h ovf=%b rv=%b want 000000 1 1", disp6, ovf6, rv6);
        end
    endtask

    task automatic test_random();
        int code, cyc;
        bit calc;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            code = ($urandom_range(0, 9) < 6) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            @(negedge clk);
            kv = 1'b1;
            kc = 4'(code);
            @(negedge clk);
            kv = 1'b0;
            model_key(code, calc);
            if (calc) begin
                measure_busy(cyc);
                n_tests++;
                if (cyc != 4) begin n_fail++; $display("FAIL rnd_busy it=%0d: got %0d want 4", it, cyc); end
            end
            n_tests++;
            if (disp !== exp_disp()) begin
                n_fail++;
                $display("FAIL rnd_disp it=%0d key=%0d: got %h want %h", it, code, disp, exp_disp());
            end
            n_tests++;
            if ({neg, ovf, sub, busy, rv} !== {m_neg, m_ovf, m_sub, 1'b0, calc}) begin
                n_fail++;
                $display("FAIL rnd_flags it=%0d key=%0d: got neg=%b ovf=%b sub=%b busy=%b rv=%b want %b %b %b 0 %b",
                         it, code, neg, ovf, sub, busy, rv, m_neg, m_ovf, m_sub, calc);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_sub_chain();
        test_entry_limit();
        test_busy_drop();
        test_digits6();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
